sparce_mem_cam: RTL and testbench
=================================

Name: sparce_mem_cam

Overview:
- Fully associative sparse memory: stores up to ENTRIES address/data pairs drawn from a 2^ADDR_WIDTH address space.
- Reads of addresses that were never written, or that have been freed, return a fill pattern.
- Successor to the flat sparse-memory port set. Adds per-byte write enables, registered read with hit indication, explicit entry release, occupancy/full status and a write-overflow error.
- Sits behind the sparse-memory bus as synthesizable backing store.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- BC, 4, bytes per data word (data width = 8*BC).
- ENTRIES, 16, number of storage slots (>=2).
- FILL_BYTE, 8'h00, byte value returned for unwritten bytes/addresses.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- cs  in  1  chip select, active low; when 1, we/re/free_req are ignored.
- we  in  1  write request.
- be  in  BC  byte write enables, bit i covers write_data[i].
- write_address  in  ADDR_WIDTH  write address.
- write_data  in  BC x 8  write data, packed bytes.
- re  in  1  read request.
- read_address  in  ADDR_WIDTH  read address.
- read_data  out  BC x 8  read data, registered.
- read_valid  out  1  read_data valid this cycle.
- read_hit  out  1  read address was resident.
- free_req  in  1  release request.
- free_address  in  ADDR_WIDTH  address to release.
- used_count  out  $clog2(ENTRIES+1)  number of valid slots.
- full  out  1  used_count==ENTRIES.
- wr_err  out  1  one-cycle pulse: write miss dropped while full.

Behaviour:
- Reset (nrst=0, async): all slot valid bits cleared. read_data=all FILL_BYTE, read_valid=0, read_hit=0, used_count=0, full=0, wr_err=0. Slot data contents need not reset.
- Operation accepted on a rising edge with cs=0. Read, write and free may all occur in the same cycle.
- Invariant: no two valid slots hold the same address.
- Write hit (write_address matches a valid slot): bytes with be[i]=1 updated, others kept. be=0 is a legal no-op.
- Write miss, not full: allocate the lowest-index invalid slot; store the tag; bytes with be[i]=1 take write_data, others take FILL_BYTE; used_count+1.
- Write miss while full: nothing stored; wr_err=1 for exactly the following cycle.
- Read: the cycle after acceptance, read_valid=1.
  - Hit: read_hit=1, read_data=slot data.
  - Miss: read_hit=0, read_data=all FILL_BYTE.
  - read_valid=0 in cycles without an accepted read; read_data holds its last value.
- Read latency 1 cycle, fully pipelined: back-to-back reads every cycle.
- Read and write to the same address in one cycle: read returns pre-write contents (read-before-write).
- Read and free of the same address in one cycle: read returns pre-free contents, read_hit=1.
- Free hit: slot valid cleared, used_count-1. Free miss: no effect, no error.
- Free and write to the same address in one cycle: write wins. Slot stays/becomes valid with the written bytes, and used_count reflects the write only.
- Free of address A and write miss to address B while full, same cycle: the freed slot is not reusable that cycle. Write is dropped, wr_err pulses, used_count ends at ENTRIES-1.
- Write allocate and free (different addresses) in one cycle: used_count unchanged.
- full and used_count are registered, updated on the same edge as the slot state.
- Reset asserted mid-operation: in-flight read discarded (read_valid=0 immediately). All entries lost.

Test Plan:
- Reset, then read 0x1000 -> next cycle read_valid=1, read_hit=0, read_data=0x00000000; used_count=0.
- Write 0x1000 data 0xAABBCCDD be=4'b0101, then read 0x1000 -> read_hit=1, data 0x00BB00DD; used_count=1. Write 0x1000 data 0x11223344 be=4'b1000, read -> 0x11BB00DD, used_count=1.
- Write 16 distinct addresses -> full=1, used_count=16. 17th new address -> wr_err one cycle, read of it -> read_hit=0. Rewrite a resident address -> no wr_err.
- Full; free a resident address X while writing new address Y in the same cycle -> wr_err=1, used_count=15, X miss, Y miss. Write Y next cycle -> hit, used_count=16.
- Same-cycle read and write of 0x20 (old 0x01010101, new 0xFFFFFFFF be=4'hF) -> read_data=0x01010101; subsequent read -> 0xFFFFFFFF.
- Reads every cycle to alternating resident/non-resident addresses with cs toggling high mid-stream -> read_valid only for cs=0 cycles, correct hit/data each. Assert nrst during a read -> read_valid drops immediately, used_count=0 after release.

Source files
------------

// File: rtl/sparce_mem_cam.sv
// Fully associative sparse memory: ENTRIES tagged slots with byte-enabled writes,
// registered reads with hit flag, explicit release, occupancy and overflow error.
module sparce_mem_cam #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         BC         = 4,
  parameter int         ENTRIES    = 16,
  parameter logic [7:0] FILL_BYTE  = 8'h00,
  localparam int        CW         = $clog2(ENTRIES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [BC-1:0]         be,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [BC*8-1:0]       write_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [BC*8-1:0]       read_data,
  output logic                  read_valid,
  output logic                  read_hit,
  input  logic                  free_req,
  input  logic [ADDR_WIDTH-1:0] free_address,
  output logic [CW-1:0]         used_count,
  output logic                  full,
  output logic                  wr_err
);

  localparam logic [BC*8-1:0] FILL_WORD = {BC{FILL_BYTE}};

  logic [ENTRIES-1:0]    r_valid;
  logic [ADDR_WIDTH-1:0] r_tag  [ENTRIES];
  logic [BC*8-1:0]       r_data [ENTRIES];
  logic [BC*8-1:0]       r_read_data;
  logic                  r_read_valid;
  logic                  r_read_hit;
  logic [CW-1:0]         r_used_count;
  logic                  r_full;
  logic                  r_wr_err;

  logic                  w_acc;
  logic [ENTRIES-1:0]    w_wr_match;
  logic [ENTRIES-1:0]    w_fr_match;
  logic [ENTRIES-1:0]    w_rd_match;
  logic [ENTRIES-1:0]    w_alloc_oh;
  logic                  w_found;
  logic [BC*8-1:0]       w_rd_data;
  logic                  w_do_wr;
  logic                  w_wr_hit;
  logic                  w_alloc;
  logic                  w_drop;
  logic                  w_do_free;
  logic [CW-1:0]         w_used_next;

  always_comb begin
    w_wr_match = '0;
    w_fr_match = '0;
    w_rd_match = '0;
    w_alloc_oh = '0;
    w_found    = 1'b0;
    w_rd_data  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_wr_match[i] = r_valid[i] && (r_tag[i] == write_address);
      w_fr_match[i] = r_valid[i] && (r_tag[i] == free_address);
      w_rd_match[i] = r_valid[i] && (r_tag[i] == read_address);
      if (w_rd_match[i]) w_rd_data = w_rd_data | r_data[i];
      // Allocation only sees slots free before this edge; a same-cycle release is not reusable.
      if (!r_valid[i] && !w_found) begin
        w_alloc_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign w_acc       = ~cs;
  assign w_do_wr     = w_acc & we;
  assign w_wr_hit    = |w_wr_match;
  assign w_alloc     = w_do_wr & ~w_wr_hit & w_found;
  assign w_drop      = w_do_wr & ~w_wr_hit & ~w_found;
  // A write to the address being freed takes precedence over the release.
  assign w_do_free   = w_acc & free_req & (|w_fr_match) &
                       ~(w_do_wr & (free_address == write_address));
  assign w_used_next = r_used_count + CW'(w_alloc) - CW'(w_do_free);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_alloc && w_alloc_oh[i])          r_valid[i] <= 1'b1;
        else if (w_do_free && w_fr_match[i])   r_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_alloc && w_alloc_oh[i]) begin
        r_tag[i] <= write_address;
        for (int b = 0; b < BC; b++)
          r_data[i][b*8 +: 8] <= be[b] ? write_data[b*8 +: 8] : FILL_BYTE;
      end else if (w_do_wr && w_wr_match[i]) begin
        for (int b = 0; b < BC; b++)
          if (be[b]) r_data[i][b*8 +: 8] <= write_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_read_data  <= FILL_WORD;
      r_read_valid <= 1'b0;
      r_read_hit   <= 1'b0;
      r_used_count <= '0;
      r_full       <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_read_valid <= w_acc & re;
      if (w_acc && re) begin
        r_read_hit  <= |w_rd_match;
        r_read_data <= (|w_rd_match) ? w_rd_data : FILL_WORD;
      end
      r_used_count <= w_used_next;
      r_full       <= (w_used_next == CW'(ENTRIES));
      r_wr_err     <= w_drop;
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign read_hit   = r_read_hit;
  assign used_count = r_used_count;
  assign full       = r_full;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_sparce_mem_cam.sv
// Directed bench for sparce_mem_cam: associative-array reference model feeds a
// read scoreboard; occupancy, full and wr_err are checked every step.
module tb_sparce_mem_cam;

  localparam int CW = 5;
  localparam logic [31:0] FILL = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cs = 1'b1;
  logic          we = 1'b0;
  logic [3:0]    be = '0;
  logic [31:0]   write_address = '0;
  logic [31:0]   write_data = '0;
  logic          re = 1'b0;
  logic [31:0]   read_address = '0;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          read_hit;
  logic          free_req = 1'b0;
  logic [31:0]   free_address = '0;
  logic [CW-1:0] used_count;
  logic          full;
  logic          wr_err;

  sparce_mem_cam #(.ADDR_WIDTH(32), .BC(4), .ENTRIES(16), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .nrst(nrst), .cs(cs), .we(we), .be(be),
    .write_address(write_address), .write_data(write_data),
    .re(re), .read_address(read_address), .read_data(read_data),
    .read_valid(read_valid), .read_hit(read_hit),
    .free_req(free_req), .free_address(free_address),
    .used_count(used_count), .full(full), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } rd_t;

  rd_t         q[$];
  logic [31:0] m_data [logic [31:0]];
  logic [31:0] last_data = FILL;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  // One clock: drive inputs, update the model, then check outputs after the edge.
  task automatic step(input bit c, input bit w, input logic [3:0] b, input logic [31:0] wa,
                      input logic [31:0] wd, input bit r, input logic [31:0] ra,
                      input bit f, input logic [31:0] fa);
    bit  acc, exp_rv, exp_err, was_full;
    rd_t e;
    cs = c; we = w; be = b; write_address = wa; write_data = wd;
    re = r; read_address = ra; free_req = f; free_address = fa;
    acc      = !c;
    exp_rv   = acc && r;
    exp_err  = 1'b0;
    was_full = (m_data.num() == 16);
    if (exp_rv) begin
      e.hit  = m_data.exists(ra);
      e.data = e.hit ? m_data[ra] : FILL;
      q.push_back(e);
    end
    if (acc && w) begin
      if (m_data.exists(wa))  m_data[wa] = merge(m_data[wa], wd, b);
      else if (!was_full)     m_data[wa] = merge(FILL, wd, b);
      else                    exp_err = 1'b1;
    end
    if (acc && f && m_data.exists(fa) && !(acc && w && fa == wa)) m_data.delete(fa);
    @(posedge clk);
    #1;
    chk("read_valid", 64'(read_valid), 64'(exp_rv));
    if (exp_rv) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("read_hit", 64'(read_hit), 64'(e.hit));
        chk("read_data", 64'(read_data), 64'(e.data));
        last_data = e.data;
      end
    end else begin
      chk("read_data_hold", 64'(read_data), 64'(last_data));
    end
    chk("used_count", 64'(used_count), 64'(m_data.num()));
    chk("full", 64'(full), 64'(m_data.num() == 16));
    chk("wr_err", 64'(wr_err), 64'(exp_err));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    step(0, 1, b, a, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(0, 0, 0, 0, 0, 1, a, 0, 0);
  endtask

  initial begin
    #12;
    chk("rst_read_valid", 64'(read_valid), 64'd0);
    chk("rst_read_hit", 64'(read_hit), 64'd0);
    chk("rst_read_data", 64'(read_data), 64'(FILL));
    chk("rst_used", 64'(used_count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    rd(32'h1000);
    wr(32'h1000, 32'hAABBCCDD, 4'b0101);
    rd(32'h1000);
    chk("be0101_data", 64'(read_data), 64'h00BB00DD);
    wr(32'h1000, 32'h11223344, 4'b1000);
    rd(32'h1000);
    chk("be1000_data", 64'(read_data), 64'h11BB00DD);
    chk("be1000_used", 64'(used_count), 64'd1);

    for (int i = 0; i < 15; i++) wr(32'h2000 + 32'(4 * i), 32'h0100 + 32'(i), 4'hF);
    chk("fill_full", 64'(full), 64'd1);
    wr(32'h9000, 32'hDEADBEEF, 4'hF);
    chk("overflow_err", 64'(wr_err), 64'd1);
    rd(32'h9000);
    chk("overflow_err_one_cycle", 64'(wr_err), 64'd0);
    wr(32'h2000, 32'h5555AAAA, 4'hF);
    rd(32'h2000);

    step(0, 1, 4'hF, 32'h3000, 32'h33333333, 0, 0, 1, 32'h1000);
    chk("free_write_full_used", 64'(used_count), 64'd15);
    rd(32'h1000);
    rd(32'h3000);
    wr(32'h3000, 32'h33333333, 4'hF);
    rd(32'h3000);
    chk("y_after_free_used", 64'(used_count), 64'd16);

    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h2004);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h2008);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777);
    wr(32'h20, 32'h01010101, 4'hF);
    step(0, 1, 4'hF, 32'h20, 32'hFFFFFFFF, 1, 32'h20, 0, 0);
    chk("rbw_old", 64'(read_data), 64'h01010101);
    rd(32'h20);
    chk("rbw_new", 64'(read_data), 64'hFFFFFFFF);
    step(0, 0, 0, 0, 0, 1, 32'h20, 1, 32'h20);
    chk("read_free_hit", 64'(read_hit), 64'd1);
    rd(32'h20);
    step(0, 1, 4'h3, 32'h40, 32'hCAFEF00D, 0, 0, 1, 32'h200C);
    rd(32'h40);
    step(0, 1, 4'hF, 32'h2010, 32'h12345678, 0, 0, 1, 32'h2010);
    rd(32'h2010);
    wr(32'h2010, 32'h0, 4'h0);

    for (int i = 0; i < 10; i++)
      step((i == 3 || i == 4 || i == 7), 0, 0, 0, 0, 1,
           (i % 2 == 0) ? 32'h2010 : 32'h9999_0000, 0, 0);
    step(1, 1, 4'hF, 32'h2010, 32'h0BAD0BAD, 1, 32'h2010, 1, 32'h2010);
    rd(32'h2010);

    cs = 0; we = 0; free_req = 0; re = 1; read_address = 32'h2010;
    @(posedge clk); #1;
    chk("pre_rst_read_valid", 64'(read_valid), 64'd1);
    cs = 1; re = 0;
    nrst = 1'b0;
    #1;
    chk("mid_rst_read_valid", 64'(read_valid), 64'd0);
    chk("mid_rst_used", 64'(used_count), 64'd0);
    chk("mid_rst_full", 64'(full), 64'd0);
    m_data.delete();
    q.delete();
    last_data = FILL;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    rd(32'h2010);
    chk("post_rst_used", 64'(used_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
